// File: rtl/rm_symbol_encoder.sv
// Commit-stream symbol encoder: classifies committed instructions into 8-bit
// symbols, buffers them in a small FIFO and streams them to an automata stage.
module rm_symbol_encoder #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        trace_start,
  input  logic        trace_end,
  input  logic        commit_valid,
  output logic        commit_ready,
  input  logic [31:0] commit_instr,
  input  logic        commit_ex,
  input  logic        mon_enable,
  output logic [7:0]  top_symbols,
  output logic        run,
  output logic        mon_reset,
  output logic        busy,
  output logic [15:0] symbol_count,
  output logic [1:0]  state_dbg
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, CLEAR = 2'd1, STREAM = 2'd2, DRAIN = 2'd3} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [7:0]      top_q, top_d;
  logic            run_q, run_d;
  logic [15:0]     sc_q, sc_d;
  logic            prev_lw_q, prev_lw_d;
  logic [4:0]      prev_rd_q, prev_rd_d;
  logic [7:0]      fifo_q [FIFO_DEPTH];

  // Handshake: a commit transfers on any rising edge where commit_valid and
  // commit_ready are both high; commit_ready never looks at commit_valid.
  logic            handshake, push, pop, emit;
  logic [7:0]      emit_sym;
  logic [7:0]      enc_sym;

  logic [6:0]      opcode;
  logic [4:0]      rd, rs1;
  logic [2:0]      funct3;
  logic            is_load, is_store, is_branch, is_lw, fwd;
  logic [2:0]      sym_class;
  logic [3:0]      sym_low;
  logic            unused_instr;

  assign opcode       = commit_instr[6:0];
  assign rd           = commit_instr[11:7];
  assign funct3       = commit_instr[14:12];
  assign rs1          = commit_instr[19:15];
  assign unused_instr = ^commit_instr[31:20];

  assign is_load   = (opcode == 7'b0000011);
  assign is_store  = (opcode == 7'b0100011);
  assign is_branch = (opcode == 7'b1100011);
  assign is_lw     = is_load && (funct3 == 3'b010);

  always_comb begin
    sym_class = 3'd0;
    if (commit_ex)                            sym_class = 3'd6;
    else if (is_lw)                           sym_class = 3'd1;
    else if (is_store && funct3 == 3'b010)    sym_class = 3'd2;
    else if (is_load)                         sym_class = 3'd3;
    else if (is_store)                        sym_class = 3'd4;
    else if (is_branch)                       sym_class = 3'd5;
  end

  // Load-use hint: this instruction reads the register the previous clean lw wrote.
  assign fwd     = prev_lw_q && (rs1 == prev_rd_q) && (prev_rd_q != 5'd0);
  assign sym_low = (sym_class == 3'd1 || sym_class == 3'd3) ? rd[3:0] : 4'd0;
  assign enc_sym = {sym_class, fwd, sym_low};

  assign commit_ready = !reset && (state_q == STREAM) && (count_q < CW'(FIFO_DEPTH));
  assign handshake    = commit_valid && commit_ready;

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    top_d     = top_q;
    run_d     = 1'b0;
    sc_d      = sc_q;
    prev_lw_d = prev_lw_q;
    prev_rd_d = prev_rd_q;
    push      = 1'b0;
    pop       = 1'b0;
    emit      = 1'b0;
    emit_sym  = 8'h00;

    case (state_q)
      IDLE: begin
        if (trace_start) state_d = CLEAR;
      end
      CLEAR: begin
        state_d   = STREAM;
        wr_ptr_d  = '0;
        rd_ptr_d  = '0;
        count_d   = '0;
        sc_d      = 16'd0;
        prev_lw_d = 1'b0;
        prev_rd_d = 5'd0;
      end
      STREAM: begin
        if (trace_start) begin
          state_d = CLEAR;
        end else begin
          if (trace_end) state_d = DRAIN;
          push = handshake;
          pop  = (count_q != '0) && mon_enable;
        end
      end
      DRAIN: begin
        if (trace_start) begin
          state_d = CLEAR;
        end else if (count_q != '0) begin
          pop = mon_enable;
        end else if (mon_enable) begin
          emit     = 1'b1;
          emit_sym = 8'hFF;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (push) begin
      wr_ptr_d  = wr_ptr_q + PW'(1);
      prev_lw_d = is_lw && !commit_ex;
      prev_rd_d = rd;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
      emit     = 1'b1;
      emit_sym = fifo_q[rd_ptr_q];
    end
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);

    if (emit) begin
      top_d = emit_sym;
      run_d = 1'b1;
      if (sc_q != 16'hFFFF) sc_d = sc_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      top_q     <= 8'h00;
      run_q     <= 1'b0;
      sc_q      <= 16'd0;
      prev_lw_q <= 1'b0;
      prev_rd_q <= 5'd0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      top_q     <= top_d;
      run_q     <= run_d;
      sc_q      <= sc_d;
      prev_lw_q <= prev_lw_d;
      prev_rd_q <= prev_rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push) fifo_q[wr_ptr_q] <= enc_sym;
  end

  assign top_symbols  = top_q;
  assign run          = run_q;
  assign symbol_count = sc_q;
  assign mon_reset    = reset || (state_q == CLEAR);
  assign busy         = !reset && (state_q != IDLE);
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_rm_symbol_encoder.sv
// Scoreboarded bench for rm_symbol_encoder: directed commits with hand-encoded
// symbols go into exp_q; a negedge monitor compares every run=1 output.
module tb_rm_symbol_encoder;

  localparam logic [1:0] S_IDLE = 2'd0, S_CLEAR = 2'd1, S_STREAM = 2'd2, S_DRAIN = 2'd3;

  logic        clk = 1'b0;
  logic        reset, trace_start, trace_end, commit_valid, commit_ex, mon_enable;
  logic [31:0] commit_instr;
  logic        commit_ready, run, mon_reset, busy;
  logic [7:0]  top_symbols;
  logic [15:0] symbol_count;
  logic [1:0]  state_dbg;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_q[$];

  always #5 clk = ~clk;

  rm_symbol_encoder #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .trace_start(trace_start), .trace_end(trace_end),
    .commit_valid(commit_valid), .commit_ready(commit_ready), .commit_instr(commit_instr),
    .commit_ex(commit_ex), .mon_enable(mon_enable), .top_symbols(top_symbols), .run(run),
    .mon_reset(mon_reset), .busy(busy), .symbol_count(symbol_count), .state_dbg(state_dbg)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    logic [7:0] e;
    if (!reset && run) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_symbol: got %02h, expected none", top_symbols);
      end else begin
        e = exp_q.pop_front();
        if (top_symbols !== e) begin
          errors++;
          $display("FAIL symbol: got %02h, expected %02h", top_symbols, e);
        end
      end
    end
  end

  task automatic send(input logic [31:0] instr, input logic ex, input logic [7:0] exp,
                      input logic with_end = 1'b0);
    int n = 0;
    commit_valid = 1'b1;
    commit_instr = instr;
    commit_ex    = ex;
    while (!commit_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("send_ready", commit_ready, 1);
    if (commit_ready) begin
      exp_q.push_back(exp);
      if (with_end) begin
        trace_end = 1'b1;
        exp_q.push_back(8'hFF);
      end
      @(negedge clk);
    end
    commit_valid = 1'b0;
    commit_ex    = 1'b0;
    trace_end    = 1'b0;
  endtask

  task automatic pulse_start();
    trace_start = 1'b1;
    @(negedge clk);
    trace_start = 1'b0;
  endtask

  task automatic pulse_end();
    trace_end = 1'b1;
    exp_q.push_back(8'hFF);
    @(negedge clk);
    trace_end = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(name, busy, 0);
    @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; trace_start = 1'b0; trace_end = 1'b0; commit_valid = 1'b0;
    commit_ex = 1'b0; commit_instr = 32'h0; mon_enable = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_top", top_symbols, 8'h00);
    check("rst_run", run, 0);
    check("rst_mon_reset", mon_reset, 1);
    check("rst_ready", commit_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_count", symbol_count, 0);
    check("rst_state", state_dbg, S_IDLE);
    reset = 1'b0;
    @(negedge clk);
    check("idle_mon_reset", mon_reset, 0);

    // Basic encoding of every class plus 2-cycle latency
    pulse_start();
    check("clear_mon_reset", mon_reset, 1);
    check("clear_ready", commit_ready, 0);
    check("clear_state", state_dbg, S_CLEAR);
    @(negedge clk);
    check("stream_mon_reset", mon_reset, 0);
    check("stream_ready", commit_ready, 1);
    send(32'h00032283, 1'b0, 8'h25);   // lw x5,0(x6)
    @(negedge clk);
    check("lat2_run", run, 1);
    check("lat2_top", top_symbols, 8'h25);
    send(32'h00532023, 1'b0, 8'h40);   // sw x5,0(x6)
    send(32'h00008483, 1'b0, 8'h69);   // lb x9,0(x1)
    send(32'h00530023, 1'b0, 8'h80);   // sb
    send(32'h00000063, 1'b0, 8'hA0);   // beq
    send(32'h003100B3, 1'b0, 8'h00);   // add
    send(32'h00032283, 1'b1, 8'hC0);   // lw with exception
    send(32'h0002A383, 1'b0, 8'h27);   // lw x7,0(x5): previous lw faulted, no hint
    send(32'h00002A83, 1'b0, 8'h25);   // lw x21,0(x0): rd[3:0]=5
    send(32'h000A8483, 1'b0, 8'h79);   // lb x9,0(x21): hint set
    pulse_end();
    wait_idle("t1_idle");
    check("t1_count", symbol_count, 11);
    check("t1_queue_empty", exp_q.size(), 0);

    // lw chain, rd=x0 pair, trace_end in a handshake cycle
    pulse_start();
    send(32'h00032283, 1'b0, 8'h25);
    send(32'h0002A383, 1'b0, 8'h37);
    send(32'h00032003, 1'b0, 8'h20);
    send(32'h00002383, 1'b0, 8'h27, 1'b1);
    wait_idle("t2_idle");
    check("t2_count", symbol_count, 5);
    check("t2_queue_empty", exp_q.size(), 0);

    // FIFO full backpressure and pointer wrap
    mon_enable = 1'b0;
    pulse_start();
    send(32'h00002083, 1'b0, 8'h21);
    send(32'h00002103, 1'b0, 8'h22);
    send(32'h00002183, 1'b0, 8'h23);
    send(32'h00002203, 1'b0, 8'h24);
    commit_valid = 1'b1;
    commit_instr = 32'h00022303;
    check("full_ready", commit_ready, 0);
    repeat (2) @(negedge clk);
    check("full_ready_held", commit_ready, 0);
    check("full_no_run", run, 0);
    mon_enable = 1'b1;
    send(32'h00022303, 1'b0, 8'h36);   // lw x6,0(x4): hint from lw x4
    send(32'h00002383, 1'b0, 8'h27);
    pulse_end();
    wait_idle("t3_idle");
    check("t3_count", symbol_count, 7);

    // Abort mid-stream with start+end together: start wins
    mon_enable = 1'b0;
    pulse_start();
    send(32'h00002103, 1'b0, 8'h22);
    send(32'h00002083, 1'b0, 8'h21);
    trace_start = 1'b1;
    trace_end   = 1'b1;
    exp_q.delete();
    @(negedge clk);
    trace_start = 1'b0;
    trace_end   = 1'b0;
    check("abort_mon_reset", mon_reset, 1);
    check("abort_state", state_dbg, S_CLEAR);
    check("abort_count", symbol_count, 0);
    @(negedge clk);
    check("abort_stream", state_dbg, S_STREAM);
    mon_enable = 1'b1;
    repeat (4) @(negedge clk);
    send(32'h00008483, 1'b0, 8'h69);   // lb x9,0(x1): previous-lw was cleared
    @(negedge clk);
    check("t4_count_one", symbol_count, 1);
    pulse_end();
    wait_idle("t4_idle");
    check("t4_count", symbol_count, 2);

    // Reset during DRAIN
    mon_enable = 1'b0;
    pulse_start();
    send(32'h00002083, 1'b0, 8'h21);
    send(32'h00002103, 1'b0, 8'h22);
    pulse_end();
    check("drain_state", state_dbg, S_DRAIN);
    check("drain_ready", commit_ready, 0);
    reset = 1'b1;
    exp_q.delete();
    #1;
    check("rst2_mon_reset_now", mon_reset, 1);
    @(negedge clk);
    check("rst2_state", state_dbg, S_IDLE);
    check("rst2_run", run, 0);
    check("rst2_top", top_symbols, 8'h00);
    check("rst2_busy", busy, 0);
    check("rst2_count", symbol_count, 0);
    reset = 1'b0;
    mon_enable = 1'b1;
    @(negedge clk);
    check("post_rst_run", run, 0);
    check("post_rst_mon_reset", mon_reset, 0);
    repeat (4) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rm_symbol_encoder.md
RM_SYMBOL_ENCODER -- requirements
Module: rm_symbol_encoder

Interface
REQ-001 Parameter: FIFO_DEPTH, default 4, number of buffered commit entries (power of two, at least 2).
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: trace_start  input  1  one-cycle pulse that opens a monitored trace.
REQ-005 Port: trace_end  input  1  one-cycle pulse that closes the trace.
REQ-006 Port: commit_valid  input  1  the core offers a committed instruction.
REQ-007 Port: commit_ready  output  1  the encoder accepts the offered instruction.
REQ-008 Port: commit_instr  input  32  raw committed instruction word.
REQ-009 Port: commit_ex  input  1  the committed instruction raised an exception.
REQ-010 Port: mon_enable  input  1  the downstream automata stage may consume a symbol this cycle.
REQ-011 Port: top_symbols  output  8  encoded symbol driven to the automata stage.
REQ-012 Port: run  output  1  top_symbols is valid this cycle.
REQ-013 Port: mon_reset  output  1  resets the automata stage.
REQ-014 Port: busy  output  1  high in every state except IDLE.
REQ-015 Port: symbol_count  output  16  number of symbols emitted since the last trace_start, saturating.

Function
REQ-016 The FSM SHALL have four states: IDLE, CLEAR, STREAM, DRAIN.
REQ-017 In IDLE, trace_start SHALL move the FSM to CLEAR; trace_end SHALL be ignored.
REQ-018 CLEAR SHALL last exactly one cycle and perform all of the following:
- drive mon_reset=1;
- empty the FIFO;
- zero symbol_count;
- clear the previous-lw register;
- move the FSM to STREAM.
REQ-019 commit_ready SHALL equal (state==STREAM) AND (FIFO count < FIFO_DEPTH).
REQ-020 commit_ready SHALL be computed from the registered count only, never from a same-cycle pop.
REQ-021 A handshake occurs when commit_valid and commit_ready are both 1; each handshake SHALL push exactly one encoded symbol.
REQ-022 Symbol bits [7:5] SHALL hold the class, decided in this priority order:
- 6 if commit_ex=1;
- 1 for opcode 0000011 with funct3 010 (lw);
- 2 for opcode 0100011 with funct3 010 (sw);
- 3 for any other 0000011 (other load);
- 4 for any other 0100011 (other store);
- 5 for opcode 1100011 (branch);
- 0 for everything else.
REQ-023 Symbol bit [4] SHALL be 1 when all three hold: the previous accepted instruction was an lw without exception; the current rs1 equals that lw's rd; that rd is non-zero.
REQ-024 Symbol bits [3:0] SHALL be rd[3:0] for classes 1 and 3, and 0 for all other classes.
REQ-025 The previous-lw register SHALL update on every handshake.
REQ-026 Output behaviour per cycle:
- if the FIFO is non-empty and mon_enable=1, the head entry SHALL be popped and registered onto top_symbols with run=1 in the next cycle;
- otherwise run=0 and top_symbols holds its last value.
REQ-027 Minimum latency SHALL be 2 cycles: a symbol pushed at edge N is popped at edge N+1 and is visible with run=1 after edge N+1.
REQ-028 A push and a pop in the same cycle SHALL leave the FIFO count unchanged.
REQ-029 FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-030 trace_end in STREAM SHALL move the FSM to DRAIN; a handshake in that same cycle SHALL still be accepted.
REQ-031 DRAIN SHALL accept no new commits and SHALL keep emitting until the FIFO is empty.
REQ-032 Once the FIFO is empty, DRAIN SHALL emit end marker 8'hFF with run=1 in the next cycle that has mon_enable=1, then return to IDLE.
REQ-033 trace_start in STREAM or DRAIN SHALL abort the trace and go to CLEAR; FIFO contents are discarded and no end marker is sent.
REQ-034 symbol_count SHALL increment on every run=1 cycle, the end marker included, and saturate at 16'hFFFF.
REQ-035 trace_start and trace_end asserted in the same cycle: trace_start SHALL win.

Reset
REQ-036 While reset=1, the block SHALL hold:
- FSM=IDLE, FIFO empty, previous-lw register cleared;
- top_symbols=8'h00, run=0, mon_reset=1, commit_ready=0, busy=0, symbol_count=0.
REQ-037 Reset SHALL override every other input, including mid-trace, and nothing SHALL be emitted on the cycle after reset deasserts.

Verification
REQ-038 reset, then trace_start, then one lw x5,0(x6) (32'h00032283) with mon_enable=1 -> mon_reset=1 for one cycle; two cycles after the handshake, top_symbols=8'h25 with run=1.
REQ-039 lw x5 followed by lw x7,0(x5) (32'h0002A383) -> second symbol=8'h37; the same pair with rd=x0 -> bit4=0.
REQ-040 mon_enable=0, then push 5 instructions back-to-back -> commit_ready drops after 4 handshakes; raising mon_enable -> 4 symbols emitted in FIFO order with correct pointer wrap.
REQ-041 trace_end with 3 entries queued -> 3 symbols, then 8'hFF, then IDLE; symbol_count=4.
REQ-042 trace_start in mid-STREAM with 2 entries queued -> mon_reset pulse, queued symbols never emitted, symbol_count=0.
REQ-043 reset asserted during DRAIN -> next cycle: IDLE, run=0, top_symbols=8'h00, no end marker emitted.
